alu_wb_regfile: RTL and testbench
=================================

ALU_WB_REGFILE -- requirements
Module: alu_wb_regfile

Interface
REQ-001 Parameter DW, 8, data width of register entries and ALU operands.
REQ-002 Parameter AW, 3, register address width (2**AW = 8 entries).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ra_addr  input  AW  operand-A read address.
REQ-007 rb_addr  input  AW  operand-B read address.
REQ-008 a  output  DW  operand A, drives alu_8bit port a.
REQ-009 b  output  DW  operand B, drives alu_8bit port b.
REQ-010 wr_en  input  1  write-back strobe for ALU result.
REQ-011 wr_addr  input  AW  write-back destination.
REQ-012 wr_data  input  DW  write-back data, driven from alu_8bit res.
REQ-013 flag_we  input  1  capture strobe for ALU flags.
REQ-014 zf_in, of_in, cf_in, sf_in  input  1 each  ALU flags from alu_8bit.
REQ-015 flags  output  4  latched flags, {zf,of,cf,sf} at bits [3:0].
REQ-016 wr_cnt  output  8  count of committed register writes.

Function
REQ-017 Reads SHALL be combinational: a = R[ra_addr], b = R[rb_addr], zero-cycle latency.
REQ-018 R0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-019 On a rising clk edge with wr_en=1 and wr_addr!=0, R[wr_addr] SHALL take wr_data.
REQ-020 wr_cnt SHALL increment by 1 per committed write (wr_addr!=0), wrapping 255->0; writes to R0 SHALL NOT count.
REQ-021 On a rising edge with flag_we=1, flags SHALL take {zf_in,of_in,cf_in,sf_in}; otherwise hold.
REQ-022 wr_en and flag_we SHALL be independent; both asserted in one cycle SHALL update both.
REQ-023 Reads of the address being written in the same cycle SHALL follow REQ-044/REQ-045.
REQ-024 ra_addr==rb_addr SHALL yield identical a and b.
REQ-025 wr_en=0 SHALL leave all registers and wr_cnt unchanged regardless of wr_addr/wr_data.
REQ-026 Outputs SHALL never be X after reset for any defined input combination.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, clear R1..R7, flags and wr_cnt to 0.
REQ-028 While rst_n=0, a, b, flags and wr_cnt SHALL read 0, and wr_en/flag_we SHALL be ignored.
REQ-029 Reset asserted mid-write SHALL win: the pending write SHALL NOT commit.
REQ-030 After rst_n rises, the first write SHALL commit on the first rising edge with wr_en=1.

Configuration
REQ-040 Macro ALU_WB_BYPASS_EN selects same-cycle write-to-read forwarding.
REQ-044 With ALU_WB_BYPASS_EN defined: if wr_en=1, wr_addr!=0 and ra_addr==wr_addr, a SHALL equal wr_data in that cycle (likewise b for rb_addr).
REQ-045 Without ALU_WB_BYPASS_EN: a/b SHALL return the stored value until the edge commits, then the new value.
REQ-046 R0 SHALL read 0 in both configurations; rst_n=0 SHALL suppress forwarding.

Verification
REQ-050 Reset: rst_n=0 after writing R3=0x5A -> a=b=0, flags=0, wr_cnt=0 immediately, no clock.
REQ-051 Write/read: wr_en=1, wr_addr=5, wr_data=0x05, clock; ra=rb=5 -> a=b=0x05, wr_cnt=1.
REQ-052 R0 guard: wr_en=1, wr_addr=0, wr_data=0xFF, clock -> reading addr 0 gives 0, wr_cnt unchanged.
REQ-053 Flags: flag_we=1 with zf_in=1, others 0, clock -> flags=4'b1000; then flag_we=0, zf_in=0, clock -> flags stays 4'b1000.
REQ-054 Bypass: R2=0x10, drive wr_en=1, wr_addr=2, wr_data=0x20, ra=2 before edge -> a=0x20 with ALU_WB_BYPASS_EN, a=0x10 without; a=0x20 after edge in both.
REQ-055 Wrap: 256 committed writes to R1 from reset -> wr_cnt returns to 0; write issued with rst_n dropping before edge does not commit.

Source files
------------

// File: rtl/alu_wb_regfile.sv
// -----------------------------------------------------------------------------
// alu_wb_regfile
// Eight-entry write-back register file for an 8-bit ALU: two combinational
// read ports feed the ALU operands, one write port takes the ALU result, a
// 4-bit flag register captures {zf,of,cf,sf}, and an 8-bit counter tallies
// committed register writes. R0 is hard-wired to zero.
//
// Build option:
//   ALU_WB_BYPASS_EN - when defined, a read of the register being written in
//                      the same cycle returns the incoming write data rather
//                      than the stored value.
// -----------------------------------------------------------------------------
module alu_wb_regfile #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] a,
   output logic [DW-1:0] b,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          flag_we,
   input  logic          zf_in,
   input  logic          of_in,
   input  logic          cf_in,
   input  logic          sf_in,
   output logic [3:0]    flags,
   output logic [7:0]    wr_cnt
);

   localparam int NREG = 1 << AW;

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic [3:0]    flags_q;
   logic [3:0]    flags_d;
   logic [7:0]    wr_cnt_q;
   logic [7:0]    wr_cnt_d;
   logic          commit;

   // A write only takes effect when it targets a real register (not R0).
   assign commit = wr_en && (wr_addr != '0);

   // Next-state for register array, write counter and flag register.
   always_comb begin
      // NOTE: every target gets its hold value first so no path can infer a latch.
      regs_d   = regs_q;
      wr_cnt_d = wr_cnt_q;
      flags_d  = flags_q;
      if (commit) begin
         regs_d[wr_addr] = wr_data;
         wr_cnt_d        = wr_cnt_q + 8'd1;
      end
      regs_d[0] = '0;
      if (flag_we) begin
         flags_d = {zf_in, of_in, cf_in, sf_in};
      end
   end

   // State registers; reset clears everything at once without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage array is reset explicitly because R1..R7 must clear
         // asynchronously; this keeps the array in flops rather than a RAM.
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wr_cnt_q <= '0;
         flags_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         regs_q   <= regs_d;
         wr_cnt_q <= wr_cnt_d;
         flags_q  <= flags_d;
      end
   end

`ifdef ALU_WB_BYPASS_EN
   // Read ports with same-cycle forwarding of the pending write; reset blocks it.
   always_comb begin
      a = regs_q[ra_addr];
      b = regs_q[rb_addr];
      if (rst_n && commit && (ra_addr == wr_addr)) begin
         a = wr_data;
      end
      if (rst_n && commit && (rb_addr == wr_addr)) begin
         b = wr_data;
      end
   end
`else
   // Read ports return the stored value; a write becomes visible after its edge.
   always_comb begin
      a = regs_q[ra_addr];
      b = regs_q[rb_addr];
   end
`endif

   assign flags  = flags_q;
   assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_alu_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_regfile
// Self-checking bench for alu_wb_regfile. A behavioural model (an array of
// register values, a flag word and a write tally) predicts every observed
// output. Compile with +define+ALU_WB_BYPASS_EN to check the forwarding build.
// -----------------------------------------------------------------------------
module tb_alu_wb_regfile;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ra_addr, rb_addr, wr_addr;
   logic [7:0] a, b, wr_data;
   logic       wr_en, flag_we;
   logic       zf_in, of_in, cf_in, sf_in;
   logic [3:0] flags;
   logic [7:0] wr_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int model_mem [8];
   int model_cnt;
   int model_flags;

   alu_wb_regfile #(.DW(8), .AW(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra_addr (ra_addr),
      .rb_addr (rb_addr),
      .a       (a),
      .b       (b),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .flag_we (flag_we),
      .zf_in   (zf_in),
      .of_in   (of_in),
      .cf_in   (cf_in),
      .sf_in   (sf_in),
      .flags   (flags),
      .wr_cnt  (wr_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

`ifdef ALU_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // Value the model expects on a read port before the coming edge.
   function automatic int exp_read(input int addr);
      if (addr == 0) return 0;
      if (BYPASS && rst_n && wr_en && wr_addr != 0 && addr == int'(wr_addr))
         return int'(wr_data);
      return model_mem[addr];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) model_mem[i] = 0;
      model_cnt   = 0;
      model_flags = 0;
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_addr = 0; wr_data = 0; flag_we = 0;
      zf_in = 0; of_in = 0; cf_in = 0; sf_in = 0;
      ra_addr = 0; rb_addr = 0;
   endtask

   // Advance one rising edge and apply the spec rules to the model.
   task automatic step();
      @(posedge clk);
      if (wr_en && wr_addr != 0) begin
         model_mem[wr_addr] = wr_data;
         model_cnt          = (model_cnt + 1) % 256;
      end
      if (flag_we) model_flags = {zf_in, of_in, cf_in, sf_in};
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      checks++;
      if (a !== 8'h00 || b !== 8'h00 || flags !== 4'h0 || wr_cnt !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: a=%h b=%h flags=%h wr_cnt=%h, want all 0", a, b, flags, wr_cnt);
      end
      // Write R3=0x5A and flags, then drop reset between edges.
      wr_en = 1; wr_addr = 3; wr_data = 8'h5A; flag_we = 1; zf_in = 1; sf_in = 1;
      step();
      @(negedge clk);
      idle_inputs();
      ra_addr = 3; rb_addr = 3;
      #1;
      checks++;
      if (a !== 8'h5A || wr_cnt !== 8'd1 || flags !== 4'b1001) begin
         errors++;
         $display("FAIL pre_reset_write: a=%h wr_cnt=%0d flags=%b, want 5a 1 1001", a, wr_cnt, flags);
      end
      #2;
      rst_n = 0;
      model_reset();
      #1;
      checks++;
      if (a !== 8'h00 || b !== 8'h00 || flags !== 4'h0 || wr_cnt !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: a=%h b=%h flags=%h wr_cnt=%h, want all 0", a, b, flags, wr_cnt);
      end
      // Strobes held during reset must be ignored across edges.
      wr_en = 1; wr_addr = 3; wr_data = 8'hC3; flag_we = 1; of_in = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (a !== 8'h00 || b !== 8'h00 || flags !== 4'h0 || wr_cnt !== 8'h00) begin
         errors++;
         $display("FAIL reset_ignores_we: a=%h b=%h flags=%h wr_cnt=%h, want all 0", a, b, flags, wr_cnt);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      wr_en = 1; wr_addr = 5; wr_data = 8'h05;
      step();
      @(negedge clk);
      idle_inputs();
      ra_addr = 5; rb_addr = 5;
      #1;
      checks++;
      if (a !== 8'h05 || b !== 8'h05 || wr_cnt !== 8'd1) begin
         errors++;
         $display("FAIL write_read: a=%h b=%h wr_cnt=%0d, want 05 05 1", a, b, wr_cnt);
      end
   endtask

   task automatic test_r0_guard();
      int cnt_before;
      cnt_before = model_cnt;
      @(negedge clk);
      wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
      step();
      @(negedge clk);
      idle_inputs();
      ra_addr = 0; rb_addr = 5;
      #1;
      checks++;
      if (a !== 8'h00 || b !== 8'h05 || int'(wr_cnt) != cnt_before) begin
         errors++;
         $display("FAIL r0_guard: a=%h b=%h wr_cnt=%0d, want 00 05 %0d", a, b, wr_cnt, cnt_before);
      end
   endtask

   task automatic test_flags();
      @(negedge clk);
      flag_we = 1; zf_in = 1; of_in = 0; cf_in = 0; sf_in = 0;
      step();
      checks++;
      if (flags !== 4'b1000) begin
         errors++;
         $display("FAIL flags_capture: flags=%b, want 1000", flags);
      end
      @(negedge clk);
      flag_we = 0; zf_in = 0; of_in = 1; cf_in = 1;
      step();
      checks++;
      if (flags !== 4'b1000) begin
         errors++;
         $display("FAIL flags_hold: flags=%b, want 1000", flags);
      end
      // Register write and flag capture in the same cycle.
      @(negedge clk);
      wr_en = 1; wr_addr = 6; wr_data = 8'h66; flag_we = 1; zf_in = 0; of_in = 1; cf_in = 1; sf_in = 0;
      step();
      @(negedge clk);
      idle_inputs();
      ra_addr = 6;
      #1;
      checks++;
      if (flags !== 4'b0110 || a !== 8'h66 || int'(wr_cnt) != model_cnt) begin
         errors++;
         $display("FAIL flags_and_write: flags=%b a=%h wr_cnt=%0d, want 0110 66 %0d", flags, a, wr_cnt, model_cnt);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      wr_en = 1; wr_addr = 2; wr_data = 8'h10;
      step();
      @(negedge clk);
      wr_en = 1; wr_addr = 2; wr_data = 8'h20; ra_addr = 2; rb_addr = 0;
      #1;
      checks++;
      if (a !== (BYPASS ? 8'h20 : 8'h10) || b !== 8'h00) begin
         errors++;
         $display("FAIL bypass_pre_edge: a=%h b=%h, want %h 00", a, b, BYPASS ? 8'h20 : 8'h10);
      end
      step();
      @(negedge clk);
      wr_en = 0;
      #1;
      checks++;
      if (a !== 8'h20) begin
         errors++;
         $display("FAIL bypass_post_edge: a=%h, want 20", a);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 8'($urandom);
         flag_we = 1'($urandom_range(0, 1));
         {zf_in, of_in, cf_in, sf_in} = 4'($urandom);
         ra_addr = 3'($urandom_range(0, 7));
         rb_addr = (n % 4 == 0) ? ra_addr : 3'($urandom_range(0, 7));
         if (n % 5 == 0) ra_addr = wr_addr;
         #1;
         checks++;
         if (int'(a) != exp_read(ra_addr) || int'(b) != exp_read(rb_addr)) begin
            errors++;
            $display("FAIL random_read[%0d]: a=%h b=%h, want %h %h", n, a, b, exp_read(ra_addr), exp_read(rb_addr));
         end
         step();
         checks++;
         if (int'(flags) != model_flags || int'(wr_cnt) != model_cnt) begin
            errors++;
            $display("FAIL random_state[%0d]: flags=%b wr_cnt=%0d, want %b %0d", n, flags, wr_cnt, 4'(model_flags), model_cnt);
         end
      end
      idle_inputs();
   endtask

   task automatic test_wrap();
      @(negedge clk);
      rst_n = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1;
      for (int n = 0; n < 256; n++) begin
         @(negedge clk);
         wr_en = 1; wr_addr = 1; wr_data = 8'(n);
         step();
         if (n == 254) begin
            checks++;
            if (wr_cnt !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255: wr_cnt=%0d, want 255", wr_cnt);
            end
         end
      end
      @(negedge clk);
      idle_inputs();
      ra_addr = 1;
      #1;
      checks++;
      if (wr_cnt !== 8'd0 || a !== 8'hFF || model_cnt != 0) begin
         errors++;
         $display("FAIL wrap_zero: wr_cnt=%0d a=%h, want 0 ff", wr_cnt, a);
      end
      // Write pending when reset drops before the edge must not commit.
      wr_en = 1; wr_addr = 4; wr_data = 8'h77; ra_addr = 4;
      #2;
      rst_n = 0;
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if (a !== 8'h00 || wr_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_beats_write: a=%h wr_cnt=%0d, want 00 0", a, wr_cnt);
      end
      // First edge after release with wr_en=1 commits.
      @(negedge clk);
      rst_n = 1;
      step();
      @(negedge clk);
      wr_en = 0;
      #1;
      checks++;
      if (a !== 8'h77 || wr_cnt !== 8'd1) begin
         errors++;
         $display("FAIL first_write_after_reset: a=%h wr_cnt=%0d, want 77 1", a, wr_cnt);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_r0_guard();
      test_flags();
      test_bypass();
      test_random();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
